// File: rtl/spi_xfer_ctrl_if.sv
// Bus-side and clock-generator-side signals of the SPI transfer controller.
interface spi_xfer_ctrl_if #(
   parameter int unsigned N = 8
);
   logic         I_EN;
   logic         I_START;
   logic [N-1:0] I_TX_DATA;
   logic         I_CPHA;
   logic         I_LSB_FIRST;
   logic         I_POS_EDGE;
   logic         I_NEG_EDGE;
   logic         I_MISO;
   logic         O_GO;
   logic         O_LAST_CLK;
   logic         O_MOSI;
   logic [N-1:0] O_RX_DATA;
   logic         O_RX_VALID;
   logic         O_BUSY;

   // Controller side.
   modport slave (
      input  I_EN, I_START, I_TX_DATA, I_CPHA, I_LSB_FIRST, I_POS_EDGE, I_NEG_EDGE, I_MISO,
      output O_GO, O_LAST_CLK, O_MOSI, O_RX_DATA, O_RX_VALID, O_BUSY
   );

   // Driver side (bus plus clock generator).
   modport master (
      output I_EN, I_START, I_TX_DATA, I_CPHA, I_LSB_FIRST, I_POS_EDGE, I_NEG_EDGE, I_MISO,
      input  O_GO, O_LAST_CLK, O_MOSI, O_RX_DATA, O_RX_VALID, O_BUSY
   );
endinterface

// File: rtl/spi_xfer_ctrl.sv
// SPI transfer controller: drives spi_clk_gen for exactly N SCK periods, shifts one word
// out on MOSI and captures one word from MISO, counting generator edge pulses.
module spi_xfer_ctrl #(
   parameter int unsigned N = 8
) (
   input logic            I_SYS_CLK,
   input logic            I_RST,
   spi_xfer_ctrl_if.slave bus
);

   localparam int unsigned CntW = $clog2(2 * N + 1);

   typedef enum logic [1:0] {StIdle, StXfer, StDone} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [N-1:0]      tx_sr_q, tx_sr_d;
   logic [N-1:0]      rx_sr_q, rx_sr_d;
   logic [N-1:0]      rx_data_q, rx_data_d;
   logic              cpha_q, cpha_d;
   logic              lsb_q, lsb_d;
   logic              go_q, go_d;
   logic              last_q, last_d;
   logic              mosi_q, mosi_d;
   logic              rx_valid_q, rx_valid_d;
   logic              busy_q, busy_d;

   logic              edge_hit;
   logic [CntW-1:0]   cnt_nxt;
   logic [N-1:0]      tx_shift;
   logic [N-1:0]      rx_shift;
   logic              is_final;
   logic              do_sample;
   logic              do_shift;
   logic              drive_first;

   // Bit that goes on the wire first for the selected bit order.
   function automatic logic lead_bit(logic [N-1:0] v, logic lsb);
      return lsb ? v[0] : v[N-1];
   endfunction

   // Edge classification and next-state for FSM, shifters and registered outputs.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      tx_sr_d    = tx_sr_q;
      rx_sr_d    = rx_sr_q;
      rx_data_d  = rx_data_q;
      cpha_d     = cpha_q;
      lsb_d      = lsb_q;
      go_d       = go_q;
      last_d     = last_q;
      mosi_d     = mosi_q;
      rx_valid_d = 1'b0;
      busy_d     = busy_q;

      // Simultaneous pulses count as a single edge.
      edge_hit    = bus.I_POS_EDGE | bus.I_NEG_EDGE;
      cnt_nxt     = cnt_q + CntW'(1);
      tx_shift    = lsb_q ? (tx_sr_q >> 1) : (tx_sr_q << 1);
      rx_shift    = lsb_q ? {bus.I_MISO, rx_sr_q[N-1:1]} : {rx_sr_q[N-2:0], bus.I_MISO};
      is_final    = (cnt_nxt == CntW'(2 * N));
      do_sample   = cpha_q ? ~cnt_nxt[0] : cnt_nxt[0];
      // CPHA=1 edge 1 presents the loaded bit without advancing the shifter.
      drive_first = cpha_q & (cnt_nxt == CntW'(1));
      do_shift    = cpha_q ? (cnt_nxt[0] & ~drive_first) : (~cnt_nxt[0] & ~is_final);

      unique case (state_q)
         StIdle: begin
            if (bus.I_START && bus.I_EN) begin
               state_d = StXfer;
               cnt_d   = '0;
               tx_sr_d = bus.I_TX_DATA;
               rx_sr_d = '0;
               cpha_d  = bus.I_CPHA;
               lsb_d   = bus.I_LSB_FIRST;
               go_d    = 1'b1;
               busy_d  = 1'b1;
               mosi_d  = bus.I_CPHA ? 1'b0 : lead_bit(bus.I_TX_DATA, bus.I_LSB_FIRST);
            end
         end
         StXfer: begin
            if (edge_hit) begin
               cnt_d = cnt_nxt;
               if (do_sample) rx_sr_d = rx_shift;
               if (do_shift) begin
                  tx_sr_d = tx_shift;
                  mosi_d  = lead_bit(tx_shift, lsb_q);
               end
               if (drive_first) mosi_d = lead_bit(tx_sr_q, lsb_q);
               if (cnt_nxt == CntW'(2 * N - 2)) last_d = 1'b1;
               if (is_final) begin
                  state_d    = StDone;
                  go_d       = 1'b0;
                  last_d     = 1'b0;
                  rx_data_d  = do_sample ? rx_shift : rx_sr_q;
                  rx_valid_d = 1'b1;
               end
            end
         end
         StDone: begin
            state_d = StIdle;
            busy_d  = 1'b0;
            mosi_d  = 1'b0;
         end
         default: state_d = StIdle;
      endcase

      // Disable aborts without touching the last received word.
      if (!bus.I_EN && state_q != StIdle) begin
         state_d    = StIdle;
         cnt_d      = '0;
         tx_sr_d    = '0;
         rx_sr_d    = '0;
         go_d       = 1'b0;
         last_d     = 1'b0;
         mosi_d     = 1'b0;
         rx_valid_d = 1'b0;
         busy_d     = 1'b0;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge I_SYS_CLK) begin
      if (I_RST) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         tx_sr_q    <= '0;
         rx_sr_q    <= '0;
         rx_data_q  <= '0;
         cpha_q     <= 1'b0;
         lsb_q      <= 1'b0;
         go_q       <= 1'b0;
         last_q     <= 1'b0;
         mosi_q     <= 1'b0;
         rx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         tx_sr_q    <= tx_sr_d;
         rx_sr_q    <= rx_sr_d;
         rx_data_q  <= rx_data_d;
         cpha_q     <= cpha_d;
         lsb_q      <= lsb_d;
         go_q       <= go_d;
         last_q     <= last_d;
         mosi_q     <= mosi_d;
         rx_valid_q <= rx_valid_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.O_GO       = go_q;
   assign bus.O_LAST_CLK = last_q;
   assign bus.O_MOSI     = mosi_q;
   assign bus.O_RX_DATA  = rx_data_q;
   assign bus.O_RX_VALID = rx_valid_q;
   assign bus.O_BUSY     = busy_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed bench for spi_xfer_ctrl; edge pulses are generated here in place of spi_clk_gen.
module tb_spi_xfer_ctrl;

   localparam int N    = 8;
   localparam int TwoN = 2 * N;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   spi_xfer_ctrl_if #(.N(N)) bus ();

   spi_xfer_ctrl #(.N(N)) dut (
      .I_SYS_CLK (clk),
      .I_RST     (rst),
      .bus       (bus)
   );

   int n_checks = 0;
   int n_errors = 0;
   logic [N-1:0] last_rx = '0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic bit_at(logic [N-1:0] w, int i, logic lsb);
      return lsb ? w[i] : w[N-1-i];
   endfunction

   // One-cycle edge pulse; odd edges are rising (CPOL=0 view), even edges falling.
   task automatic pulse(input int k);
      bus.I_POS_EDGE = k[0];
      bus.I_NEG_EDGE = ~k[0];
      tick();
      bus.I_POS_EDGE = 1'b0;
      bus.I_NEG_EDGE = 1'b0;
   endtask

   task automatic check_idle(input string tag, input logic [N-1:0] rx_exp);
      check_eq({tag, "_go"}, bus.O_GO, 1'b0);
      check_eq({tag, "_busy"}, bus.O_BUSY, 1'b0);
      check_eq({tag, "_mosi"}, bus.O_MOSI, 1'b0);
      check_eq({tag, "_last"}, bus.O_LAST_CLK, 1'b0);
      check_eq({tag, "_valid"}, bus.O_RX_VALID, 1'b0);
      check_eq({tag, "_rx"}, bus.O_RX_DATA, rx_exp);
   endtask

   // Full transfer with per-edge checks; poke pulses I_START during XFER and DONE.
   task automatic xfer(input logic [N-1:0] tx, input logic [N-1:0] rxw, input logic cpha,
                       input logic lsb, input int gap, input logic poke);
      bus.I_START     = 1'b1;
      bus.I_TX_DATA   = tx;
      bus.I_CPHA      = cpha;
      bus.I_LSB_FIRST = lsb;
      tick();
      bus.I_START   = 1'b0;
      bus.I_TX_DATA = ~tx;
      bus.I_CPHA    = ~cpha;
      check_eq("start_busy", bus.O_BUSY, 1'b1);
      check_eq("start_go", bus.O_GO, 1'b1);
      check_eq("start_mosi", bus.O_MOSI, cpha ? 1'b0 : bit_at(tx, 0, lsb));
      for (int k = 1; k <= TwoN; k++) begin
         // Sample edges: odd for CPHA=0, even for CPHA=1; bit index is (k-1)/2 either way.
         if (cpha ? !k[0] : k[0]) bus.I_MISO = bit_at(rxw, (k - 1) / 2, lsb);
         pulse(k);
         if (k < TwoN) begin
            if (cpha ? k[0] : !k[0])
               check_eq($sformatf("mosi_e%0d", k), bus.O_MOSI,
                        bit_at(tx, cpha ? (k - 1) / 2 : k / 2, lsb));
            check_eq($sformatf("last_e%0d", k), bus.O_LAST_CLK, (k >= TwoN - 2));
            check_eq($sformatf("go_e%0d", k), bus.O_GO, 1'b1);
            check_eq($sformatf("valid_e%0d", k), bus.O_RX_VALID, 1'b0);
            if (poke && k == 5) bus.I_START = 1'b1;
            for (int g = 0; g < gap; g++) begin
               tick();
               bus.I_START = 1'b0;
            end
         end else begin
            check_eq("done_go", bus.O_GO, 1'b0);
            check_eq("done_valid", bus.O_RX_VALID, 1'b1);
            check_eq("done_rx", bus.O_RX_DATA, rxw);
            check_eq("done_last", bus.O_LAST_CLK, 1'b0);
            check_eq("done_busy", bus.O_BUSY, 1'b1);
            last_rx = rxw;
         end
      end
      if (poke) begin
         bus.I_START   = 1'b1;
         bus.I_TX_DATA = 8'hFF;
      end
      tick();
      bus.I_START = 1'b0;
      check_idle("end", rxw);
      if (poke) begin
         tick();
         check_idle("poke_ignored", rxw);
      end
   endtask

   // Start and run some edges with no checking, for abort scenarios.
   task automatic partial(input logic [N-1:0] tx, input int nedges);
      bus.I_START     = 1'b1;
      bus.I_TX_DATA   = tx;
      bus.I_CPHA      = 1'b0;
      bus.I_LSB_FIRST = 1'b0;
      tick();
      bus.I_START = 1'b0;
      for (int k = 1; k <= nedges; k++) begin
         bus.I_MISO = 1'b1;
         pulse(k);
         tick();
      end
   endtask

   initial begin
      rst             = 1'b1;
      bus.I_EN        = 1'b1;
      bus.I_START     = 1'b0;
      bus.I_TX_DATA   = '0;
      bus.I_CPHA      = 1'b0;
      bus.I_LSB_FIRST = 1'b0;
      bus.I_POS_EDGE  = 1'b0;
      bus.I_NEG_EDGE  = 1'b0;
      bus.I_MISO      = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      check_idle("reset", 8'h00);

      xfer(8'hA5, 8'h3C, 1'b0, 1'b0, 1, 1'b0);
      xfer(8'h81, 8'h5A, 1'b1, 1'b1, 1, 1'b0);
      // Wider edge spacing, like a divider of 4; poke START during XFER and DONE.
      xfer(8'h3C, 8'hC3, 1'b0, 1'b1, 3, 1'b1);
      xfer(8'hC3, 8'h96, 1'b1, 1'b0, 3, 1'b0);
      // Start on the first IDLE cycle after DONE.
      xfer(8'h5A, 8'hA5, 1'b0, 1'b0, 1, 1'b0);

      // Enable dropped after edge 7.
      partial(8'hFF, 7);
      bus.I_EN = 1'b0;
      tick();
      check_idle("abort", last_rx);
      bus.I_EN = 1'b1;
      for (int k = 8; k <= TwoN; k++) begin
         pulse(k);
         tick();
      end
      check_idle("abort_after", last_rx);

      // Reset held one cycle mid-transfer.
      partial(8'hFF, 5);
      check_eq("pre_reset_go", bus.O_GO, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_idle("midrst", 8'h00);
      for (int k = 6; k <= TwoN; k++) begin
         pulse(k);
         check_eq($sformatf("midrst_mosi_e%0d", k), bus.O_MOSI, 1'b0);
         check_eq($sformatf("midrst_valid_e%0d", k), bus.O_RX_VALID, 1'b0);
         tick();
      end
      check_idle("midrst_after", 8'h00);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
